fsqrt_arbiter: RTL and testbench

Shares one fixed-latency, non-stallable fsqrt pipeline among N_REQ requesters. Each cycle it selects at most one request round-robin and drives that operand into the pipeline. It carries the requester ID alongside the operand in a tag shift register matched to the pipeline depth. It returns each result to its owner as a registered one-cycle pulse on a shared result bus.

---
 rtl/fsqrt_pkg.sv | 21 ++
 rtl/fsqrt_arbiter_rr_arbiter.sv | 37 +++
 rtl/fsqrt_arbiter.sv | 121 ++++++++++++
 tb/tb_fsqrt_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fsqrt_pkg.sv
// Shared types and constants for the fsqrt request arbiter.
package fsqrt_pkg;

    localparam int unsigned FSQRT_LATENCY = 3;
    localparam int unsigned WORD_W        = 32;
    localparam int unsigned ID_W          = 4;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } fsqrt_tag_t;

    // Round-robin successor of requester w among n requesters.
    function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] w, input int unsigned n);
        if (32'(w) + 32'd1 >= n) begin
            return '0;
        end
        return w + ID_W'(1);
    endfunction

endpackage

// File: rtl/fsqrt_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter
    import fsqrt_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    input  logic             en_i,
    output logic [N_REQ-1:0] grant_c_o,
    output logic [ID_W-1:0]  winner_c_o,
    output logic             found_c_o
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    int unsigned idx;

    always_comb begin
        grant_c_o  = '0;
        winner_c_o = '0;
        found_c_o  = 1'b0;
        idx        = 0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            idx = 32'(ptr_i) + off;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (en_i && !found_c_o && req_i[IDX_W'(idx)]) begin
                found_c_o              = 1'b1;
                grant_c_o[IDX_W'(idx)] = 1'b1;
                winner_c_o             = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fsqrt_arbiter.sv
// Shares one fixed-latency fsqrt pipeline among N_REQ requesters, routing each
// result back to its issuer via a tag shift register matched to the pipe depth.
module fsqrt_arbiter
    import fsqrt_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned LATENCY = FSQRT_LATENCY
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [WORD_W*N_REQ-1:0] req_src,
    input  logic                    flush,
    output logic [WORD_W-1:0]       sqrt_src,
    input  logic [WORD_W-1:0]       sqrt_dest,
    output logic [N_REQ-1:0]        resp_valid,
    output logic [WORD_W-1:0]       resp_dest,
    output logic                    busy,
    output logic [WORD_W-1:0]       issue_count
);

    localparam int unsigned IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    // One extra stage covers the sqrt_src register in front of the pipeline.
    localparam int unsigned TAG_DEPTH = LATENCY + 1;

    logic [N_REQ-1:0][WORD_W-1:0] src_w;
    logic [N_REQ-1:0]             grant;
    logic [ID_W-1:0]              winner;
    logic                         fire;
    logic [WORD_W-1:0]            sel_src;
    fsqrt_tag_t                   last_tag;

    fsqrt_tag_t        tag_q [TAG_DEPTH];
    fsqrt_tag_t        tag_d [TAG_DEPTH];
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [WORD_W-1:0] sqrt_src_q, sqrt_src_d;
    logic [N_REQ-1:0]  resp_valid_q, resp_valid_d;
    logic [WORD_W-1:0] resp_dest_q, resp_dest_d;
    logic [WORD_W-1:0] issue_count_q, issue_count_d;
    logic              busy_q, busy_d;

    assign src_w = req_src;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .req_i      (req_valid),
        .ptr_i      (ptr_q),
        .en_i       (rstn & ~flush),
        .grant_c_o  (grant),
        .winner_c_o (winner),
        .found_c_o  (fire)
    );

    assign req_ready = grant;
    assign sel_src   = src_w[IDX_W'(winner)];
    assign last_tag  = tag_q[TAG_DEPTH-1];

    // Next-state: issue, tag shift, response capture, bookkeeping.
    always_comb begin
        tag_d[0]      = '0;
        ptr_d         = ptr_q;
        sqrt_src_d    = sqrt_src_q;
        resp_valid_d  = '0;
        resp_dest_d   = resp_dest_q;
        issue_count_d = issue_count_q + WORD_W'(fire);

        if (fire) begin
            tag_d[0].valid = 1'b1;
            tag_d[0].id    = winner;
            ptr_d          = rr_next(winner, N_REQ);
            sqrt_src_d     = sel_src;
        end

        for (int unsigned k = 1; k < TAG_DEPTH; k++) begin
            tag_d[k] = flush ? '0 : tag_q[k-1];
        end

        if (last_tag.valid && !flush) begin
            resp_valid_d = N_REQ'(1) << last_tag.id;
            resp_dest_d  = sqrt_dest;
        end

        busy_d = |resp_valid_d;
        for (int unsigned k = 0; k < TAG_DEPTH; k++) begin
            busy_d = busy_d | tag_d[k].valid;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned k = 0; k < TAG_DEPTH; k++) begin
                tag_q[k] <= '0;
            end
            ptr_q         <= '0;
            sqrt_src_q    <= '0;
            resp_valid_q  <= '0;
            resp_dest_q   <= '0;
            issue_count_q <= '0;
            busy_q        <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < TAG_DEPTH; k++) begin
                tag_q[k] <= tag_d[k];
            end
            ptr_q         <= ptr_d;
            sqrt_src_q    <= sqrt_src_d;
            resp_valid_q  <= resp_valid_d;
            resp_dest_q   <= resp_dest_d;
            issue_count_q <= issue_count_d;
            busy_q        <= busy_d;
        end
    end

    assign sqrt_src    = sqrt_src_q;
    assign resp_valid  = resp_valid_q;
    assign resp_dest   = resp_dest_q;
    assign issue_count = issue_count_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_fsqrt_arbiter.sv
// Bench for fsqrt_arbiter with a behavioural fixed-latency fsqrt pipeline.
module tb_fsqrt_arbiter;
    import fsqrt_pkg::*;

    localparam int unsigned N   = 4;
    localparam int unsigned LAT = FSQRT_LATENCY;
    localparam logic [32*N-1:0] SRC_DEF =
        {32'h3F800000, 32'h41800000, 32'h41100000, 32'h40800000};
    localparam logic [32*N-1:0] SRC_NINE =
        {32'h3F800000, 32'h41800000, 32'h41100000, 32'h41100000};

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [32*N-1:0] req_src = '0;
    logic            flush = 1'b0;
    logic [31:0]     sqrt_src, sqrt_dest, resp_dest, issue_count;
    logic [N-1:0]    resp_valid;
    logic            busy;

    always #5 clk = ~clk;

    fsqrt_arbiter #(.N_REQ(N), .LATENCY(LAT)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .flush(flush), .sqrt_src(sqrt_src), .sqrt_dest(sqrt_dest),
        .resp_valid(resp_valid), .resp_dest(resp_dest), .busy(busy),
        .issue_count(issue_count)
    );

    // Stand-in fsqrt: exact for the plan's operands, exponent-halving otherwise.
    function automatic logic [31:0] fsq(input logic [31:0] x);
        case (x)
            32'h40800000: return 32'h40000000;
            32'h41100000: return 32'h40400000;
            32'h41800000: return 32'h40800000;
            32'h3F800000: return 32'h3F800000;
            default:      return (x >> 1) + 32'h1FC00000;
        endcase
    endfunction

    logic [31:0] pipe [LAT];
    always_ff @(posedge clk) begin
        pipe[0] <= sqrt_src;
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign sqrt_dest = fsq(pipe[LAT-1]);

    // Reference model: pointer, counters and a queue of ops counting down to delivery.
    typedef struct { int left; int id; logic [31:0] res; } op_t;
    op_t         q[$];
    int          m_ptr;
    logic [31:0] m_src, m_dest, m_cnt;
    int          n_cmp = 0, n_err = 0;

    typedef struct {
        logic [N-1:0]    v;
        logic [32*N-1:0] src;
        logic            fl;
        logic [N-1:0]    rdy;
        logic [N-1:0]    rv;
    } vec_t;
    vec_t tab[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ptr = 0; m_src = '0; m_dest = '0; m_cnt = '0;
    endtask

    function automatic logic [N-1:0] model_grant(input logic [N-1:0] v, input logic fl);
        if (fl) return '0;
        for (int off = 0; off < N; off++) begin
            int i;
            i = (m_ptr + off) % N;
            if (v[i]) return N'(1) << i;
        end
        return '0;
    endfunction

    // One clock: drive at negedge, check grant, step model at posedge, check outputs.
    task automatic cycle(input logic [N-1:0] v, input logic [32*N-1:0] src, input logic fl,
                         input bit use_tab, input logic [N-1:0] t_rdy, input logic [N-1:0] t_rv);
        logic [N-1:0] g, erv;
        int w;
        req_valid = v; req_src = src; flush = fl;
        #1;
        g = model_grant(v, fl);
        chk("req_ready", 32'(req_ready), 32'(g));
        if (use_tab) chk("tab_ready", 32'(req_ready), 32'(t_rdy));
        @(posedge clk);
        erv = '0;
        if (fl) begin
            q.delete();
        end else begin
            for (int j = 0; j < q.size(); j++) q[j].left--;
            if (q.size() > 0 && q[0].left == 0) begin
                erv    = N'(1) << q[0].id;
                m_dest = q[0].res;
                void'(q.pop_front());
            end
        end
        if (g != '0) begin
            w = 0;
            for (int i = 0; i < N; i++) if (g[i]) w = i;
            m_src = src[32*w +: 32];
            m_ptr = (w + 1) % N;
            m_cnt = m_cnt + 32'd1;
            q.push_back('{LAT + 1, w, fsq(m_src)});
        end
        #1;
        chk("resp_valid", 32'(resp_valid), 32'(erv));
        if (use_tab) chk("tab_resp_valid", 32'(resp_valid), 32'(t_rv));
        chk("resp_dest", resp_dest, m_dest);
        chk("sqrt_src", sqrt_src, m_src);
        chk("issue_count", issue_count, m_cnt);
        chk("busy", 32'(busy), 32'((q.size() != 0) || (erv != '0)));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, SRC_DEF, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic check_reset_outputs();
        req_valid = '1;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_sqrt_src", sqrt_src, 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_dest", resp_dest, 32'd0);
        chk("rst_issue_count", issue_count, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        req_valid = '0;
    endtask

    task automatic add(input logic [N-1:0] v, input logic [32*N-1:0] src,
                       input logic [N-1:0] rdy, input logic [N-1:0] rv);
        tab.push_back('{v, src, 1'b0, rdy, rv});
    endtask

    int pulses;

    initial begin
        // Round-robin with all four requesters, then drain.
        for (int i = 0; i < 8; i++) add(4'hF, SRC_DEF, 4'(1 << (i % 4)), (i < 4) ? 4'h0 : 4'(1 << (i % 4)));
        for (int i = 0; i < 5; i++) add(4'h0, SRC_DEF, 4'h0, (i < 4) ? 4'(1 << i) : 4'h0);
        // Single request of 9.0 from requester 0.
        add(4'h1, SRC_NINE, 4'h1, 4'h0);
        for (int i = 0; i < 3; i++) add(4'h0, SRC_DEF, 4'h0, 4'h0);
        add(4'h0, SRC_DEF, 4'h0, 4'h1);
        add(4'h0, SRC_DEF, 4'h0, 4'h0);
        // Pointer to 2, then only 3 and 1 requesting.
        add(4'h2, SRC_DEF, 4'h2, 4'h0);
        add(4'hA, SRC_DEF, 4'h8, 4'h0);
        add(4'hA, SRC_DEF, 4'h2, 4'h0);
        add(4'hA, SRC_DEF, 4'h8, 4'h0);
        add(4'h0, SRC_DEF, 4'h0, 4'h2);
        add(4'h0, SRC_DEF, 4'h0, 4'h8);
        add(4'h0, SRC_DEF, 4'h0, 4'h2);
        add(4'h0, SRC_DEF, 4'h0, 4'h8);
        add(4'h0, SRC_DEF, 4'h0, 4'h0);

        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs();
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < tab.size(); i++)
            cycle(tab[i].v, tab[i].src, tab[i].fl, 1'b1, tab[i].rdy, tab[i].rv);
        chk("wrap_issue_count", issue_count, 32'd13);

        // Flush with three ops in flight; nothing of them may return.
        for (int i = 0; i < 3; i++) cycle(4'h7, SRC_DEF, 1'b0, 1'b0, '0, '0);
        cycle(4'hF, SRC_DEF, 1'b1, 1'b1, 4'h0, 4'h0);
        for (int i = 0; i < 6; i++) cycle(4'h0, SRC_DEF, 1'b0, 1'b1, 4'h0, 4'h0);
        cycle(4'h4, SRC_DEF, 1'b0, 1'b1, 4'h4, 4'h0);
        idle(3);
        cycle(4'h0, SRC_DEF, 1'b0, 1'b1, 4'h0, 4'h4);
        chk("flush_dest", resp_dest, 32'h40800000);
        idle(1);

        // Idle gaps: issues at relative edges 1, 3, 4.
        pulses = 0;
        cycle(4'h2, SRC_DEF, 1'b0, 1'b0, '0, '0);
        if (resp_valid != '0) pulses++;
        cycle(4'h0, SRC_DEF, 1'b0, 1'b0, '0, '0);
        if (resp_valid != '0) pulses++;
        cycle(4'h2, SRC_DEF, 1'b0, 1'b0, '0, '0);
        if (resp_valid != '0) pulses++;
        cycle(4'h2, SRC_DEF, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 8; i++) begin
            if (resp_valid != '0) pulses++;
            idle(1);
        end
        chk("gap_pulses", 32'(pulses), 32'd3);

        // Async reset with two ops in flight.
        cycle(4'h3, SRC_DEF, 1'b0, 1'b0, '0, '0);
        cycle(4'h3, SRC_DEF, 1'b0, 1'b0, '0, '0);
        #2;
        rstn = 1'b0;
        model_reset();
        check_reset_outputs();
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) cycle(4'h0, SRC_DEF, 1'b0, 1'b1, 4'h0, 4'h0);
        cycle(4'hF, SRC_DEF, 1'b0, 1'b1, 4'h1, 4'h0);
        idle(6);

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 400; i++)
            cycle(4'($urandom_range(0, 15)), {$urandom, $urandom, $urandom, $urandom},
                  1'($urandom_range(0, 19) == 0), 1'b0, '0, '0);
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
